// File: rtl/addr_seq_pkg.sv
// Shared definitions for the segment address sequencer: FSM states and segment
// bound helpers evaluated from the instantiating module's parameters.
package addr_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int seg_start(input int s, input int base, input int seg_len);
      return base + s * seg_len;
   endfunction

   function automatic int seg_finish(input int s, input int base, input int seg_len);
      return base + s * seg_len + seg_len - 1;
   endfunction

endpackage

// File: rtl/addr_seg_range.sv
// Combinational segment decoder: segment number to first/last address of that
// segment in a linear table of equal-length segments starting at BASE.
module addr_seg_range
   import addr_seq_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int SEG_LEN = 15,
   parameter int BASE    = 1,
   parameter int SEL_W   = 2
) (
   input  logic [SEL_W-1:0]  sel,
   output logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] finish_addr
);

   assign start_addr  = ADDR_W'(seg_start(int'(sel), BASE, SEG_LEN));
   assign finish_addr = ADDR_W'(seg_finish(int'(sel), BASE, SEG_LEN));

endmodule

// File: rtl/addr_seq.sv
// Segment address sequencer: steps a registered address through one segment on
// command. Define ADDR_SEQ_LOOP_EN to honour the loop input (wrap-around mode).
module addr_seq
   import addr_seq_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int NUM_SEG = 4,
   parameter int SEG_LEN = 15,
   parameter int BASE    = 1,
   parameter int SEL_W   = $clog2(NUM_SEG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SEL_W-1:0]  select,
   input  logic              start,
   input  logic              stop,
   input  logic              step,
   input  logic              loop,
   output logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic              done,
   output logic              wrap,
   output logic [SEL_W-1:0]  seg
);

   if (BASE + NUM_SEG * SEG_LEN - 1 >= (1 << ADDR_W)) begin : g_range_chk
      $error("addr_seq: segment table does not fit in ADDR_W bits");
   end
   if (NUM_SEG < 2 || SEG_LEN < 1) begin : g_param_chk
      $error("addr_seq: NUM_SEG must be >= 2 and SEG_LEN >= 1");
   end

   state_t            state;
   logic              loop_q;
   logic              loop_in;
   logic [SEL_W-1:0]  sel_clamp;
   logic [ADDR_W-1:0] load_addr;
   logic [ADDR_W-1:0] cur_start;
   logic [ADDR_W-1:0] cur_finish;

`ifdef ADDR_SEQ_LOOP_EN
   assign loop_in = loop;
`else
   logic loop_unused;
   assign loop_unused = loop;
   assign loop_in     = 1'b0;
`endif

   // Out-of-range selects fold onto the last segment.
   assign sel_clamp = (32'(select) >= 32'(NUM_SEG)) ? SEL_W'(NUM_SEG - 1) : select;
   assign load_addr = ADDR_W'(seg_start(int'(sel_clamp), BASE, SEG_LEN));

   addr_seg_range #(
      .ADDR_W  (ADDR_W),
      .SEG_LEN (SEG_LEN),
      .BASE    (BASE),
      .SEL_W   (SEL_W)
   ) u_range (
      .sel         (seg),
      .start_addr  (cur_start),
      .finish_addr (cur_finish)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         addr   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         wrap   <= 1'b0;
         seg    <= '0;
         loop_q <= 1'b0;
      end else begin
         done <= 1'b0;
         wrap <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  seg    <= sel_clamp;
                  loop_q <= loop_in;
                  addr   <= load_addr;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (start) begin
                  seg    <= sel_clamp;
                  loop_q <= loop_in;
                  addr   <= load_addr;
               end else if (step) begin
                  if (addr != cur_finish) begin
                     addr <= addr + ADDR_W'(1);
                  end else if (loop_q) begin
                     addr <= cur_start;
                     wrap <= 1'b1;
                  end else begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addr_seq.sv
// Scoreboard bench for addr_seq: a driver feeds directed and random commands and
// queues the reference model's expected outputs; a monitor checks after each edge.
module tb_addr_seq;

   localparam int ADDR_W  = 8;
   localparam int NUM_SEG = 4;
   localparam int SEG_LEN = 15;
   localparam int BASE    = 1;
   localparam int SEL_W   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [SEL_W-1:0]  select = '0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              step = 1'b0;
   logic              loop = 1'b0;
   logic [ADDR_W-1:0] addr;
   logic              busy;
   logic              done;
   logic              wrap;
   logic [SEL_W-1:0]  seg;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic              b;
      logic              d;
      logic              w;
      logic [SEL_W-1:0]  s;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // reference model: segment number, offset inside segment, running flag
   bit   m_run;
   int   m_seg;
   int   m_idx;
   bit   m_lp;
   int   m_addr;
   bit   m_done;
   bit   m_wrap;

   addr_seq #(
      .ADDR_W  (ADDR_W),
      .NUM_SEG (NUM_SEG),
      .SEG_LEN (SEG_LEN),
      .BASE    (BASE),
      .SEL_W   (SEL_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .select (select),
      .start  (start),
      .stop   (stop),
      .step   (step),
      .loop   (loop),
      .addr   (addr),
      .busy   (busy),
      .done   (done),
      .wrap   (wrap),
      .seg    (seg)
   );

   always #5 clk = ~clk;

   function automatic exp_t m_exp();
      exp_t e;
      e.a = ADDR_W'(m_addr);
      e.b = m_run;
      e.d = m_done;
      e.w = m_wrap;
      e.s = SEL_W'(m_seg);
      return e;
   endfunction

   function automatic void m_reset();
      m_run = 0; m_seg = 0; m_idx = 0; m_lp = 0; m_addr = 0; m_done = 0; m_wrap = 0;
   endfunction

   function automatic void m_load(input int sl, input bit lp);
      m_seg  = (sl >= NUM_SEG) ? NUM_SEG - 1 : sl;
`ifdef ADDR_SEQ_LOOP_EN
      m_lp   = lp;
`else
      m_lp   = 0;
      if (lp) m_lp = 0;
`endif
      m_idx  = 0;
      m_addr = BASE + m_seg * SEG_LEN;
   endfunction

   function automatic void m_cycle(input bit st, input bit sp, input bit stp, input int sl, input bit lp);
      m_done = 0;
      m_wrap = 0;
      if (!m_run) begin
         if (st && !sp) begin
            m_load(sl, lp);
            m_run = 1;
         end
      end else if (sp) begin
         m_run = 0;
      end else if (st) begin
         m_load(sl, lp);
      end else if (stp) begin
         if (m_idx < SEG_LEN - 1) begin
            m_idx++;
         end else if (m_lp) begin
            m_idx  = 0;
            m_wrap = 1;
         end else begin
            m_run  = 0;
            m_done = 1;
         end
         m_addr = BASE + m_seg * SEG_LEN + m_idx;
      end
   endfunction

   function automatic void check(input string name, input exp_t e);
      exp_t g;
      g = {addr, busy, done, wrap, seg};
      tests++;
      if (g !== e) begin
         fails++;
         $display("FAIL %s t=%0t: got addr=%0d busy=%0b done=%0b wrap=%0b seg=%0d, want addr=%0d busy=%0b done=%0b wrap=%0b seg=%0d",
                  name, $time, g.a, g.b, g.d, g.w, g.s, e.a, e.b, e.d, e.w, e.s);
      end
   endfunction

   task automatic cyc(input bit r, input bit st, input bit sp, input bit stp,
                      input int sl, input bit lp);
      @(negedge clk);
      rst = r; start = st; stop = sp; step = stp; select = SEL_W'(sl); loop = lp;
      if (r) begin
         m_reset();
         #1;
         check("async_reset", m_exp());
      end else begin
         m_cycle(st, sp, stp, sl, lp);
      end
      q.push_back(m_exp());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   // monitor: compare every post-edge output against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("cycle", e);
         end
      end
   end

   initial begin
      m_reset();
      // reset held
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 2, 0);
      idle(2);
      // select=2, run to done
      cyc(0, 1, 0, 0, 2, 0);
      for (int i = 0; i < SEG_LEN; i++) cyc(0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, 0, 0);
      idle(2);
      // select=3 with loop, run past the wrap, then stop
      cyc(0, 1, 0, 0, 3, 1);
      for (int i = 0; i < SEG_LEN + 2; i++) cyc(0, 0, 0, 1, 1, 0);
      cyc(0, 0, 1, 1, 0, 0);
      idle(2);
      // select=1, reach 20, stop with step high
      cyc(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 3, 1);
      cyc(0, 0, 1, 1, 2, 1);
      idle(2);
      // restart from addr 5 into segment 3 with step high
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 3, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      // start+stop together in IDLE
      cyc(0, 1, 1, 1, 2, 0);
      idle(1);
      // async reset mid-run at addr 40, then start on release
      cyc(0, 1, 0, 0, 2, 0);
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      idle(1);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 3) != 0), int'($urandom_range(0, NUM_SEG - 1)),
             bit'($urandom_range(0, 1)));
      end
      idle(2);
      @(posedge clk);
      #2;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
